// File: rtl/game_pkg.sv
// Shared definitions for the answer-input path of the game.
//   ANS_* constants : 2-bit answer codes presented to the game core
//   ans_state_t     : answer-capture FSM states (2-bit encoding)
//   lowest_set      : code of the lowest-indexed set bit of a 4-bit vector
//   count_ones      : population count of a 4-bit vector
package game_pkg;

  localparam logic [1:0] ANS_ADD  = 2'd0;
  localparam logic [1:0] ANS_SUB  = 2'd1;
  localparam logic [1:0] ANS_MUL  = 2'd2;
  localparam logic [1:0] ANS_SKIP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } ans_state_t;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] r;
    r = ANS_SKIP;
    if      (v[0]) r = ANS_ADD;
    else if (v[1]) r = ANS_SUB;
    else if (v[2]) r = ANS_MUL;
    return r;
  endfunction

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One-bit switch conditioner: 2-flop synchronizer, debounce counter,
// debounced stable level and a single-cycle press (rising-edge) event.
//   clk, reset : clock, asynchronous active-high reset
//   raw        : raw switch level, asynchronous to clk
//   stable     : debounced level
//   press      : combinational stable rising edge (stable=1, previous=0)
module switch_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      cnt         <= '0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      stable_prev <= stable;
      // Level must differ for DEBOUNCE_CYCLES consecutive edges; the
      // accepting edge is the one that finds the counter already at the last value.
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = stable & ~stable_prev;

endmodule

// File: rtl/answer_input.sv
// Answer capture for the game core: debounces four answer switches and
// presents one held answer event per debounced press with valid/ready.
//   clk, reset : clock, asynchronous active-high reset
//   switch[3:0]: raw switches (bit0 add, bit1 sub, bit2 mul, bit3 skip)
//   ans_ready  : game core accepts the presented answer
//   ans_valid  : answer event held until transfer
//   ans_code   : captured answer code
//   ans_multi  : more than one switch was debounced-high at capture
//   busy       : FSM not idle
module answer_input
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] switch,
  input  logic       ans_ready,
  output logic       ans_valid,
  output logic [1:0] ans_code,
  output logic       ans_multi,
  output logic       busy
);

  logic [3:0] stable;
  logic [3:0] press;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (switch[g]),
      .stable(stable[g]),
      .press (press[g])
    );
  end

  ans_state_t state;
  ans_state_t state_next;
  logic       capture;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press != 4'b0000) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ans_ready) begin
          state_next = (stable == 4'b0000) ? ST_IDLE : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (stable == 4'b0000) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ans_code  <= ANS_ADD;
      ans_multi <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        ans_code  <= lowest_set(press);
        ans_multi <= (count_ones(stable) > 3'd1);
      end
    end
  end

  // Derived from the state register so reset clears them asynchronously.
  assign ans_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_answer_input.sv
module tb_answer_input;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] switch = 4'b0000;
  logic       ans_ready = 1'b0;
  logic       ans_valid;
  logic [1:0] ans_code;
  logic       ans_multi;
  logic       busy;

  int checks = 0;
  int failures = 0;

  answer_input #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .switch   (switch),
    .ans_ready(ans_ready),
    .ans_valid(ans_valid),
    .ans_code (ans_code),
    .ans_multi(ans_multi),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural reference: raw -> 2-sample delay line -> level accepted once it
  // has been seen differing for DC consecutive samples; event phases as ints.
  int   m_dly1 [4];
  int   m_dly2 [4];
  int   m_lvl  [4];
  int   m_prev [4];
  int   m_run  [4];
  int   m_phase;          // 0 idle, 1 presenting, 2 waiting for release
  int   m_code;
  int   m_multi;
  int   ev_count;         // answer events presented since last clear

  function automatic logic [4:0] model_out();
    logic [4:0] r;
    r[4]   = (m_phase == 1);
    r[3:2] = 2'(m_code);
    r[1]   = (m_multi != 0);
    r[0]   = (m_phase != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dly1[i] = 0; m_dly2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0; m_run[i] = 0;
    end
    m_phase = 0; m_code = 0; m_multi = 0;
  endtask

  task automatic model_edge(input logic [3:0] sw, input logic rdy);
    int any_press, first, high, all_low;
    any_press = 0; first = -1; high = 0; all_low = 1;
    for (int i = 0; i < 4; i++) begin
      if (m_lvl[i] == 1 && m_prev[i] == 0) begin
        any_press = 1;
        if (first < 0) first = i;
      end
      high += m_lvl[i];
      if (m_lvl[i] != 0) all_low = 0;
    end
    if (m_phase == 0 && any_press != 0) begin
      m_code = first; m_multi = (high > 1); m_phase = 1; ev_count++;
    end else if (m_phase == 1 && rdy) begin
      m_phase = all_low ? 0 : 2;
    end else if (m_phase == 2 && all_low != 0) begin
      m_phase = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = m_lvl[i];
      if (m_dly2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_lvl[i] = m_dly2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_dly2[i] = m_dly1[i];
      m_dly1[i] = int'(sw[i]);
    end
  endtask

  // Drives inputs, advances one edge, updates the model, samples 1ns later.
  task automatic tick(input logic [3:0] sw, input logic rdy);
    switch = sw;
    ans_ready = rdy;
    @(posedge clk);
    model_edge(sw, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();
    #12;
    reset = 1'b0;
    @(posedge clk); #1;  // first post-reset edge is consumed by this wait
    model_edge(switch, ans_ready);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #3;
    checks++;
    if ({ans_valid, ans_code, ans_multi, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", {ans_valid, ans_code, ans_multi, busy}, 5'b0);
    end
    #20;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    model_edge(switch, ans_ready);
  endtask

  task automatic test_single_press();
    int first_valid, valid_cycles;
    first_valid = -1; valid_cycles = 0;
    for (int e = 0; e < 14; e++) begin
      tick(4'b0010, 1'b1);
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL single_press e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
      if (ans_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = e;
      end
    end
    checks++;
    if (first_valid !== DC + 2 || valid_cycles !== 1) begin
      failures++;
      $display("FAIL single_latency first=%0d cycles=%0d want first=%0d cycles=1", first_valid, valid_cycles, DC + 2);
    end
    for (int e = 0; e < 12; e++) begin
      tick(4'b0000, 1'b1);
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL single_release e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
    end
    checks++;
    if (busy !== 1'b0 || ans_code !== 2'd1) begin
      failures++;
      $display("FAIL single_final busy=%b code=%0d want busy=0 code=1", busy, ans_code);
    end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    for (int e = 0; e < 20; e++) begin
      tick((e < 3) ? 4'b0001 : 4'b0000, 1'b1);
      if (ans_valid || busy) seen++;
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL glitch e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL glitch_noevent active_cycles=%0d want=0", seen);
    end
  endtask

  task automatic test_multi_hold();
    int held;
    held = 0;
    ev_count = 0;
    for (int e = 0; e < DC + 3; e++) tick(4'b0101, 1'b0);
    for (int e = 0; e < 10; e++) begin
      // switch[2] chatters/releases/re-presses while the answer is held
      tick((e % 6 < 3) ? 4'b0101 : 4'b0001, 1'b0);
      if (ans_valid) held++;
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL multi_hold e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
    end
    checks++;
    if (held !== 10 || ans_code !== 2'd0 || ans_multi !== 1'b1) begin
      failures++;
      $display("FAIL multi_values held=%0d code=%0d multi=%b want held=10 code=0 multi=1", held, ans_code, ans_multi);
    end
    for (int e = 0; e < 20; e++) begin
      tick(4'b0000, 1'b1);
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL multi_drain e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
    end
    checks++;
    if (ev_count !== 1) begin
      failures++;
      $display("FAIL multi_single_event events=%0d want=1", ev_count);
    end
  endtask

  task automatic test_skip_repress();
    int valid_cycles, release_cycles;
    valid_cycles = 0; release_cycles = 0;
    for (int e = 0; e < 30; e++) begin
      tick(4'b1000, 1'b1);
      if (ans_valid) valid_cycles++;
      if (busy && !ans_valid) release_cycles++;
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL skip_hold e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
    end
    checks++;
    if (valid_cycles !== 1 || ans_code !== 2'd3 || release_cycles < 20) begin
      failures++;
      $display("FAIL skip_once valid=%0d code=%0d release=%0d want valid=1 code=3 release>=20", valid_cycles, ans_code, release_cycles);
    end
    for (int e = 0; e < 10; e++) tick(4'b0000, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL skip_released busy=%b want=0", busy);
    end
    valid_cycles = 0;
    for (int e = 0; e < 12; e++) begin
      tick(4'b1000, 1'b1);
      if (ans_valid) valid_cycles++;
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL skip_repress e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
    end
    checks++;
    if (valid_cycles !== 1 || ans_code !== 2'd3) begin
      failures++;
      $display("FAIL skip_second valid=%0d code=%0d want valid=1 code=3", valid_cycles, ans_code);
    end
    for (int e = 0; e < 10; e++) tick(4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid_hold();
    int first_valid;
    first_valid = -1;
    for (int e = 0; e < DC + 4; e++) tick(4'b0100, 1'b0);
    checks++;
    if (ans_valid !== 1'b1 || ans_code !== 2'd2) begin
      failures++;
      $display("FAIL rst_hold_pre valid=%b code=%0d want valid=1 code=2", ans_valid, ans_code);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({ans_valid, ans_code, busy} !== 4'b0) begin
      failures++;
      $display("FAIL rst_hold_async got=%b want=0000", {ans_valid, ans_code, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick(4'b0100, 1'b1);
      if (ans_valid && first_valid < 0) first_valid = e;
      checks++;
      if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
        failures++;
        $display("FAIL rst_hold_post e=%0d got=%b want=%b", e, {ans_valid, ans_code, ans_multi, busy}, model_out());
      end
    end
    checks++;
    if (first_valid !== DC + 2) begin
      failures++;
      $display("FAIL rst_hold_latency first=%0d want=%0d", first_valid, DC + 2);
    end
    for (int e = 0; e < 10; e++) tick(4'b0000, 1'b1);
  endtask

  task automatic test_chatter();
    int seen;
    seen = 0;
    for (int e = 0; e < 40; e++) begin
      tick(((e / 2) % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1);
      if (ans_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0 || {ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
      failures++;
      $display("FAIL chatter active=%0d got=%b want active=0 %b", seen, {ans_valid, ans_code, ans_multi, busy}, model_out());
    end
    for (int e = 0; e < 8; e++) tick(4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] sw;
    int         hold;
    int         bad;
    bad = 0;
    for (int seg = 0; seg < 250; seg++) begin
      sw   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) sw = 4'b0000;
      hold = $urandom_range(1, 12);
      for (int e = 0; e < hold; e++) begin
        tick(sw, 1'($urandom_range(0, 1)));
        checks++;
        if ({ans_valid, ans_code, ans_multi, busy} !== model_out()) begin
          failures++;
          if (bad < 10)
            $display("FAIL random seg=%0d got=%b want=%b", seg, {ans_valid, ans_code, ans_multi, busy}, model_out());
          bad++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    ev_count = 0;
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_hold();
    test_skip_repress();
    test_reset_mid_hold();
    test_chatter();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/answer_input.md
ANSWER_INPUT -- requirements
Module: answer_input

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a switch level change; legal range 1..65535.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 switch  input  4  raw player answer switches, asynchronous to clk; bit0 add, bit1 sub, bit2 mul, bit3 skip.
REQ-005 ans_ready  input  1  game core accepts the presented answer this cycle.
REQ-006 ans_valid  output  1  answer event held for the game core.
REQ-007 ans_code  output  2  answer code: 0 add, 1 sub, 2 mul, 3 skip.
REQ-008 ans_multi  output  1  more than one switch was debounced-high when the event was captured.
REQ-009 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-010 Each switch bit SHALL pass through a 2-flop synchronizer (sync1, sync2), both reset to 0.
REQ-011 Per switch, a debounce counter SHALL increment each cycle sync2 differs from the stable level and clear to 0 on any cycle they match.
REQ-012 The stable level SHALL toggle, and the counter clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 while sync2 still differs.
REQ-013 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no stable-level change.
REQ-014 A press event SHALL be the combinational rising edge of a stable level (stable=1, previous stable=0).
REQ-015 FSM states: IDLE, HOLD, RELEASE; encoding 2 bits.
REQ-016 IDLE: on any press event, register ans_code = lowest-indexed switch with a press event, register ans_multi = (count of stable-high switches > 1), go to HOLD.
REQ-017 Latency: raw switch first sampled high at edge 0, held steady -> ans_valid high after edge DEBOUNCE_CYCLES+2.
REQ-018 HOLD: ans_valid=1; ans_code and ans_multi SHALL remain constant until transfer.
REQ-019 Transfer SHALL occur on an edge where ans_valid=1 and ans_ready=1; ans_valid SHALL drop the following cycle.
REQ-020 On transfer: all four stable levels low -> IDLE; otherwise -> RELEASE.
REQ-021 Press events occurring in HOLD or RELEASE SHALL be discarded, not queued.
REQ-022 RELEASE: ans_valid=0; go to IDLE on the first edge where all four stable levels are low.
REQ-023 A switch held high continuously SHALL produce exactly one event; a new event requires debounced release then debounced press.
REQ-024 ans_ready while ans_valid=0 SHALL have no effect.
REQ-025 Debouncers SHALL keep running in every FSM state.

Reset
REQ-026 Reset SHALL force: FSM IDLE, ans_valid=0, ans_code=0, ans_multi=0, busy=0, all sync flops, stable levels, previous-stable flops and counters 0.
REQ-027 Reset asserted mid-HOLD SHALL drop ans_valid immediately (asynchronously), with no transfer.
REQ-028 A switch held high across reset deassertion SHALL produce one event DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Structure
REQ-029 Shared package game_pkg SHALL hold ANS_ADD=0, ANS_SUB=1, ANS_MUL=2, ANS_SKIP=3 and the FSM state constants.
REQ-030 Sub-module switch_debounce (synchronizer + counter + stable level + press event for one bit, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times.
REQ-031 Counter width SHALL be the minimum bits to hold DEBOUNCE_CYCLES-1 (minimum 1).

Verification (DEBOUNCE_CYCLES=4)
REQ-032 switch=0010 from edge 0, ans_ready=1 -> ans_valid high after edge 6 for one cycle, ans_code=1, ans_multi=0, busy drops after switch released and debounced.
REQ-033 switch[0] high for 3 cycles then low -> ans_valid never asserts, busy stays 0.
REQ-034 switch=0101 same cycle, ans_ready=0 for 10 cycles -> ans_valid held 10+ cycles, ans_code=0, ans_multi=1; switch[2] toggling during HOLD creates no second event.
REQ-035 switch=1000 held, ans_ready=1 -> exactly one event code=3; FSM in RELEASE until release debounced; re-press -> second event code=3.
REQ-036 Reset asserted during HOLD -> ans_valid, ans_code, busy 0 same cycle; switch still high at deassertion -> one event after edge 6 post-reset.
REQ-037 switch=0100 alternating high/low every 2 cycles for 40 cycles -> no event.
